// File: rtl/motor_pkg.sv
// rtl/motor_pkg.sv - shared types, constants and slew helper for the motor PWM driver
// Contents: state_t (IDLE/RUN/STOPPING), DIR_FWD/DIR_REV, DUTY_W, wide_t, step_toward().
package motor_pkg;

    localparam int DUTY_W = 13;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam logic DIR_FWD = 1'b0;
    localparam logic DIR_REV = 1'b1;

    // One bit wider than a duty value so cur + step cannot wrap.
    typedef logic [DUTY_W:0] wide_t;

    // Move cur toward goal by at most step. It lands exactly on goal when
    // closer than step. A decrement clamps at goal, and goal is never below 0,
    // so the value never wraps.
    function automatic logic [DUTY_W-1:0] step_toward(
        input logic [DUTY_W-1:0] cur,
        input logic [DUTY_W-1:0] goal,
        input wide_t             step
    );
        wide_t c;
        wide_t g;
        wide_t up;
        wide_t dn;
        c  = {1'b0, cur};
        g  = {1'b0, goal};
        up = c + step;
        dn = (c > step) ? (c - step) : '0;
        if (c < g) begin
            step_toward = (up > g) ? goal : up[DUTY_W-1:0];
        end else begin
            step_toward = (dn < g) ? goal : dn[DUTY_W-1:0];
        end
    endfunction

endpackage

// File: rtl/pwm_period_cnt.sv
// rtl/pwm_period_cnt.sv - free-running PWM period counter with registered end-of-period tick
// Ports: sys_clk, sys_rst_n (async active-low); cnt = 0..PERIOD-1;
//        period_tick = high while cnt == PERIOD-1.
module pwm_period_cnt #(
    parameter int PERIOD = 5000,
    parameter int CNT_W  = 13
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    output logic [CNT_W-1:0] cnt,
    output logic             period_tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0] PRE  = CNT_W'(PERIOD - 2);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt         <= '0;
            period_tick <= 1'b0;
        end else begin
            cnt         <= (cnt == LAST) ? '0 : cnt + 1'b1;
            // Registered: it is decoded one count early so it lines up with cnt == LAST.
            period_tick <= (cnt == PRE);
        end
    end

endmodule

// File: rtl/motor_pwm_drv.sv
// rtl/motor_pwm_drv.sv - glitch-free H-bridge PWM drive with period-aligned duty updates
// Ports: sys_clk, sys_rst_n (async active-low); mod (target duty, clock counts);
//        run, dir (0 fwd / 1 rev); pwm_in1/pwm_in2 (bridge drive); duty_cur;
//        period_tick; busy (state STOPPING).
// Option: MOTOR_PWM_SOFT_RAMP_EN limits duty slew to STEP per period. Without it,
//         the duty value jumps straight to its goal.
module motor_pwm_drv
    import motor_pkg::*;
#(
    parameter int PERIOD = 5000,
    parameter int STEP   = 50
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DUTY_W-1:0] mod,
    input  logic              run,
    input  logic              dir,
    output logic              pwm_in1,
    output logic              pwm_in2,
    output logic [DUTY_W-1:0] duty_cur,
    output logic              period_tick,
    output logic              busy
);

`ifdef MOTOR_PWM_SOFT_RAMP_EN
    localparam bit RAMP_ON = 1'b1;
`else
    localparam bit RAMP_ON = 1'b0;
`endif

    localparam logic [DUTY_W-1:0] PERIOD_V = DUTY_W'(PERIOD);
    // Without ramping, a slew of PERIOD covers any distance, so the duty value jumps.
    localparam wide_t             SLEW_V   = wide_t'(RAMP_ON ? STEP : PERIOD);

    logic [DUTY_W-1:0] cnt;
    logic [DUTY_W-1:0] tgt;
    logic [DUTY_W-1:0] goal;
    logic [DUTY_W-1:0] duty_nxt;
    state_t            state;
    state_t            state_nxt;
    logic              cur_dir;
    logic              cur_dir_nxt;

    pwm_period_cnt #(
        .PERIOD (PERIOD),
        .CNT_W  (DUTY_W)
    ) u_cnt (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .cnt         (cnt),
        .period_tick (period_tick)
    );

    assign tgt = (mod > PERIOD_V) ? PERIOD_V : mod;

    // Next state is evaluated every cycle but only committed on period_tick.
    // On each tick the duty value steps toward the goal of the state being
    // entered: tgt when entering or staying in RUN, 0 otherwise. As a result,
    // a stop starts falling on the tick that leaves RUN, and a restart starts
    // rising on the tick that enters RUN.
    always_comb begin
        state_nxt   = state;
        cur_dir_nxt = cur_dir;
        goal        = '0;
        case (state)
            IDLE: begin
                if (run) begin
                    state_nxt   = RUN;
                    cur_dir_nxt = dir;
                end
            end
            RUN: begin
                if (!run || (dir != cur_dir)) begin
                    state_nxt = STOPPING;
                end
            end
            STOPPING: begin
                if (duty_cur == '0) begin
                    if (run) begin
                        state_nxt   = RUN;
                        cur_dir_nxt = dir;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (state_nxt == RUN) begin
            goal = tgt;
        end
        duty_nxt = step_toward(duty_cur, goal, SLEW_V);
        busy     = (state == STOPPING);
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state    <= IDLE;
            cur_dir  <= DIR_FWD;
            duty_cur <= '0;
            pwm_in1  <= 1'b0;
            pwm_in2  <= 1'b0;
        end else begin
            if (period_tick) begin
                state    <= state_nxt;
                cur_dir  <= cur_dir_nxt;
                duty_cur <= duty_nxt;
            end
            // Both legs come from the same registered cur_dir, so they can
            // never be high together. cur_dir only changes while the duty value is 0.
            pwm_in1 <= (cur_dir == DIR_FWD) && (cnt < duty_cur);
            pwm_in2 <= (cur_dir == DIR_REV) && (cnt < duty_cur);
        end
    end

endmodule
